// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adder_pkg                                                 |
// | Purpose  : Shared constants for the pipelined add/subtract unit:     |
// |            default segment width, stage-count helper and op-select   |
// |            encoding.                                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package adder_pkg;

  // Bits resolved per pipeline stage unless overridden
  localparam int SEG_W_DEFAULT = 4;

  // Op-select encoding carried on the 'sub' input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of pipeline stages (and the latency) for a given split
  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/pipe_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_adder_if                                             |
// | Purpose  : Operand/result streaming bus of pipe_adder with a         |
// |            valid/ready handshake on each side. 'master' is the       |
// |            environment (producer + consumer), 'slave' the adder.     |
// |            Macro PIPE_ADDER_OVF_EN adds the signed-overflow signal.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface pipe_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

`ifdef PIPE_ADDER_OVF_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface : pipe_adder_if
`default_nettype wire

// File: rtl/pipe_adder_seg_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_adder                                                 |
// | Purpose  : Combinational SEG_W-bit ripple of full adders. Also       |
// |            exposes the carry into the segment MSB so the caller can  |
// |            derive signed overflow.                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module seg_adder
  import adder_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  wire [SEG_W-1:0] a_i,
  input  wire [SEG_W-1:0] b_i,
  input  wire             ci_i,
  output logic [SEG_W-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  // Carry chain: w_c[i] is the carry into bit i
  logic [SEG_W:0] w_c;

  // Ripple the carry through one full adder per bit
  always_comb begin
    w_c    = '0;
    s_o    = '0;
    w_c[0] = ci_i;
    for (int i = 0; i < SEG_W; i++) begin
      s_o[i]     = a_i[i] ^ b_i[i] ^ w_c[i];
      w_c[i + 1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o       = w_c[SEG_W];
  assign c_msb_in_o = w_c[SEG_W-1];

endmodule : seg_adder
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_adder                                                |
// | Purpose  : Pipelined WIDTH-bit add/subtract, one SEG_W-bit segment   |
// |            per stage with the carry registered between stages.       |
// |            Latency NSEG = WIDTH/SEG_W, one op per cycle, global      |
// |            stall when the result is not taken.                       |
// |            Optional: define PIPE_ADDER_OVF_EN for the registered     |
// |            signed-overflow output 'ovf'.                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  wire         clk,
  input  wire         rst_n,
  pipe_adder_if.slave bus
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  logic             w_adv;
  logic             w_out_valid;
  logic             w_c0;
  logic [WIDTH-1:0] w_b_eff;

  // The whole pipe moves together; it only freezes while a result waits
  assign w_out_valid  = g_stage[NSEG-1].vld_q;
  assign w_adv        = !w_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Subtraction is a + ~b + 1: invert B on capture and force the first carry
  assign w_b_eff = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
  assign w_c0    = (bus.sub == OP_SUB) ? 1'b1   : bus.cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Operand bits still to be summed when entering stage k
    localparam int REM_W = WIDTH - k * SEG_W;
    // Result bits finished once stage k has run
    localparam int LO_W  = (k + 1) * SEG_W;

    logic [REM_W-1:0] w_rem_a;
    logic [REM_W-1:0] w_rem_b;
    logic             w_c_in;
    logic             w_v_in;
    logic [SEG_W-1:0] w_s;
    logic             w_co;
    logic             w_cmsb;
    logic             w_cmsb_unused;
    logic [LO_W-1:0]  w_lo_d;

    logic             vld_q;
    logic             c_q;
    logic [LO_W-1:0]  lo_q;

    if (k == 0) begin : g_first
      assign w_rem_a = bus.a;
      assign w_rem_b = w_b_eff;
      assign w_c_in  = w_c0;
      assign w_v_in  = bus.in_valid;
      assign w_lo_d  = w_s;
    end else begin : g_next
      assign w_rem_a = g_stage[k-1].g_hi.a_q;
      assign w_rem_b = g_stage[k-1].g_hi.b_q;
      assign w_c_in  = g_stage[k-1].c_q;
      assign w_v_in  = g_stage[k-1].vld_q;
      assign w_lo_d  = {w_s, g_stage[k-1].lo_q};
    end

    seg_adder #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i        (w_rem_a[SEG_W-1:0]),
      .b_i        (w_rem_b[SEG_W-1:0]),
      .ci_i       (w_c_in),
      .s_o        (w_s),
      .co_o       (w_co),
      .c_msb_in_o (w_cmsb)
    );

    // Only the last segment's MSB carry-in feeds overflow
    assign w_cmsb_unused = w_cmsb;

    // Stage register: valid, finished low bits and the segment carry-out
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        lo_q  <= '0;
      end else if (w_adv) begin
        vld_q <= w_v_in;
        c_q   <= w_co;
        lo_q  <= w_lo_d;
      end
    end

    if (k < NSEG - 1) begin : g_hi
      logic [REM_W-SEG_W-1:0] a_q;
      logic [REM_W-SEG_W-1:0] b_q;

      // Carry the not-yet-summed high operand segments down the pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (w_adv) begin
          a_q <= w_rem_a[REM_W-1:SEG_W];
          b_q <= w_rem_b[REM_W-1:SEG_W];
        end
      end
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.sum       = g_stage[NSEG-1].lo_q;
  assign bus.cout      = g_stage[NSEG-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow = carry into MSB xor carry out of MSB, captured with sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (w_adv) begin
      ovf_q <= g_stage[NSEG-1].w_cmsb ^ g_stage[NSEG-1].w_co;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule : pipe_adder
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipe_adder                                             |
// | Purpose  : Scoreboard bench for pipe_adder (WIDTH=8, SEG_W=4).       |
// |            Driver pushes expected results on acceptance, a monitor   |
// |            pops and compares on every output handshake.              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_pipe_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  pipe_adder_if #(.WIDTH(8)) bus ();

  pipe_adder #(
    .WIDTH (8),
    .SEG_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result for the sweep: a + (sub ? ~b : b) + (sub ? 1 : cin)
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] r;
    bb     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + {8'b0, (sub ? 1'b1 : cin)};
    e.sum  = r[7:0];
    e.cout = r[8];
    e.ovf  = (a[7] == bb[7]) && (r[7] != a[7]);
    return e;
  endfunction

  // Offer one op; push its expected result in the cycle it is accepted
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [7:0] esum, input logic ecout,
                      input logic eovf);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    #1;
    while (!bus.in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=0 for 50 cycles, op a=0x%0h b=0x%0h", a, b);
      bus.in_valid = 1'b0;
    end else begin
      e.sum  = esum;
      e.cout = ecout;
      e.ovf  = eovf;
      q.push_back(e);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic sub);
    exp_t e;
    e = model(a, b, cin, sub);
    send(a, b, cin, sub, e.sum, e.cout, e.ovf);
  endtask

  task automatic count_valid(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) cnt++;
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (q.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    check(name, q.size(), 0);
  endtask

  // Monitor: every output handshake must match the oldest expected entry
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: sum=0x%0h cout=%0b with no op pending", bus.sum, bus.cout);
        end else begin
          e = q.pop_front();
          check("result", {23'b0, bus.cout, bus.sum}, {23'b0, e.cout, e.sum});
`ifdef PIPE_ADDER_OVF_EN
          check("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    int g;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h12;
    bus.b         = 8'h34;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held with an op offered: nothing may be captured
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_sum", {24'b0, bus.sum}, 0);
    check("rst_cout", {31'b0, bus.cout}, 0);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", {31'b0, bus.ovf}, 0);
`endif
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 1);
    count_valid(4, cnt);
    check("no_op_from_reset", cnt, 0);

    // Latency: visible after the second edge following acceptance
    send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_edge1_valid", {31'b0, bus.out_valid}, 0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", {31'b0, bus.out_valid}, 1);
    drain("drain_latency");

    // Directed vectors, back to back
    send(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    send(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    send(8'h40, 8'h10, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    send(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    send(8'h8F, 8'h01, 1'b1, 1'b0, 8'h91, 1'b0, 1'b0);
    drain("drain_directed");

    // Streamed sweep: every a against boundary-heavy b values
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        logic [7:0] bv;
        case (bi)
          0: bv = 8'h00;  1: bv = 8'h01;  2: bv = 8'h0F;  3: bv = 8'h10;
          4: bv = 8'h7F;  5: bv = 8'h80;  6: bv = 8'hF0;  default: bv = 8'hFF;
        endcase
        send_model(ai[7:0], bv, ai[0] ^ bi[0], ((ai + bi) % 3) == 0);
      end
    end
    drain("drain_sweep");

    // Backpressure: result held for five cycles, nothing lost
    @(negedge clk);
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
        send(8'h20, 8'h02, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);
        send(8'h30, 8'h03, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
      end
      begin
        g = 0;
        do begin
          @(negedge clk);
          #3;
          g++;
        end while (!bus.out_valid && g < 20);
        check("bp_first_valid", {31'b0, bus.out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) begin
            @(negedge clk);
            #3;
          end
          check("bp_hold_sum", {24'b0, bus.sum}, 32'h11);
          check("bp_in_ready", {31'b0, bus.in_ready}, 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Mid-flight reset: both in-flight ops are discarded
    send(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    send(8'h44, 8'h55, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_rst_valid", {31'b0, bus.out_valid}, 0);
    check("async_rst_sum", {24'b0, bus.sum}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(8, cnt);
    check("no_result_after_reset", cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_pipe_adder
`default_nettype wire

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit. It is the clocked successor of the 4-bit ripple full-adder block.
- Splits a WIDTH-bit operation into SEG_W-bit segments, one segment resolved per pipeline stage, with the carry registered between stages.
- Uses a valid/ready handshake on both sides, so it sits between streaming datapath stages and accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be a multiple of SEG_W.
- SEG_W, 4: segment width per pipeline stage. NSEG = WIDTH/SEG_W is the number of stages and the latency.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: an operation is offered.
- in_ready, output, 1: the unit can accept; the transfer happens when in_valid && in_ready.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in; used only when sub=0.
- sub, input, 1: 0 selects a+b+cin; 1 selects a-b (a+~b+1), cin ignored.
- out_valid, output, 1: a result is presented.
- out_ready, input, 1: the consumer accepts; the transfer happens when out_valid && out_ready.
- sum, output, WIDTH: result modulo 2^WIDTH.
- cout, output, 1: carry-out of the MSB. When sub=1, cout=1 means no borrow (a>=b unsigned).

Behaviour:
- Single clock. Reset is asynchronous and active-low. While rst_n=0: all stage valid bits=0, out_valid=0, sum=0, cout=0, in_ready=1 one cycle after release.
- Pipeline: stage k (k=0..NSEG-1) computes bits [k*SEG_W +: SEG_W] from the registered carry of stage k-1.
  - Stage 0 carry-in = sub ? 1 : cin.
  - B is inverted on capture when sub=1.
  - Each stage register holds: valid, finished low segments, the unprocessed high segments of a and b, and the carry.
- Latency: a transfer accepted at edge T gives out_valid=1 after edge T+NSEG-1, so the result is visible in the cycle after the NSEG-th capture. With defaults (NSEG=2) the result is visible 2 cycles after acceptance, provided there is no stall.
- Flow control: a global advance signal adv = !out_valid || out_ready. All stage registers load only when adv=1; in_ready = adv (combinational).
  - When out_valid=1 and out_ready=0, every stage holds. Bubbles are not compressed, sum and cout are stable, and in_ready=0.
  - A bubble (in_valid=0 while adv=1) propagates as valid=0; its data fields are don't-care.
- Throughput: 1 op/cycle while out_ready=1.
- Simultaneous events:
  - Output handshake and new input in the same cycle are both legal; the pipeline shifts once.
  - out_ready while out_valid=0 has no effect.
- Arithmetic: unsigned modular. cout is the carry out of segment NSEG-1 and is never sticky.
- Reset mid-operation: all in-flight ops are discarded and none appear after reset.
- Outputs are registered (sum, cout, out_valid come from flops). in_ready is the only combinational output.
- NSEG=1 (SEG_W=WIDTH) is legal and gives latency 1.

Optional Feature:
- PIPE_ADDER_OVF_EN
  - Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the selected operation, equal to the carry into the MSB XOR the carry out of the MSB. It is registered alongside sum, reset to 0, and held on stall.
  - Undefined: the port is absent and no overflow logic is synthesised.

Decomposition:
- Package adder_pkg: the default SEG_W constant, a localparam function computing NSEG, and the op-select encoding constants (OP_ADD=1'b0, OP_SUB=1'b1).
- Sub-module seg_adder: combinational SEG_W-bit ripple of full adders. Inputs a, b, ci; outputs s, co, and c_msb_in (for overflow). Instantiated NSEG times via generate.

Test Plan (WIDTH=8, SEG_W=4, latency 2):
1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, cout=0; after release, the first valid result appears only for ops accepted after release.
2. Exhaustive add: stream all 256x256 (a,b) with cin=0/1 and out_ready=1 -> each result {cout,sum}=a+b+cin in order, 2 cycles after its acceptance, one per cycle. Spot checks: 0xFF+0x01+0 gives sum=0x00, cout=1; 0x0F+0x01 gives 0x10, cout=0 (segment carry crossing).
3. Subtract: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0. a=0x07, b=0x05 -> sum=0x02, cout=1.
4. Backpressure: stream 0x10+0x01, 0x20+0x02, 0x30+0x03 with out_ready held 0 for 5 cycles after the first out_valid -> sum stays 0x11, in_ready=0, no loss. On release, 0x11, 0x22, 0x33 arrive in order.
5. Mid-flight reset: two ops in flight, pulse rst_n=0 asynchronously between edges -> out_valid drops immediately and neither result ever appears.
6. With PIPE_ADDER_OVF_EN defined: 0x7F+0x01 -> ovf=1; 0x80-0x01 (sub) -> ovf=1; 0x40+0x10 -> ovf=0.
